// File: rtl/alu_pkg.sv
// Shared ALUOp encodings and the issue-slot payload type for the execute-stage issue path.
package alu_pkg;
    localparam int ALU_WIDTH  = 32;
    localparam int ALU_RIDX_W = 5;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;

    typedef struct packed {
        logic [1:0]           aluop;
        logic [ALU_WIDTH-1:0] a;
        logic [ALU_WIDTH-1:0] b;
    } alu_issue_t;
endpackage

// File: rtl/issue_skid_buf.sv
// Two-entry valid/ready pipeline register: a main slot driving the output and a skid slot
// that catches the op accepted while main is stalled. Ready is registered (!skid_valid).
import alu_pkg::*;

module issue_skid_buf #(
    parameter type T = alu_issue_t
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);
    logic main_valid, skid_valid;
    T     main_q, skid_q;
    logic accept, drain;

    assign accept    = in_valid & in_ready;
    assign drain     = main_valid & out_ready;
    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || drain) begin
            // A full skid blocks accept, so the skid entry is always the older op here.
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_q     <= in_data;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_q     <= in_data;
            skid_valid <= 1'b1;
        end
    end
endmodule

// File: rtl/alu_operand_issue.sv
// Execute-stage issue: resolves A/B from register file, EX/WB forwards or immediate at
// accept time and hands {aluop, a, b} to the arithmetic unit through a skid buffer.
import alu_pkg::*;

module alu_operand_issue #(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int IMM_W  = 16,
    parameter int RIDX_W = ALU_RIDX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_aluop,
    input  logic [RIDX_W-1:0] in_rs_idx,
    input  logic [RIDX_W-1:0] in_rt_idx,
    input  logic [WIDTH-1:0]  in_rs_val,
    input  logic [WIDTH-1:0]  in_rt_val,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic              in_use_imm,
    input  logic              in_sign_ext,
    input  logic              fwd_ex_en,
    input  logic [RIDX_W-1:0] fwd_ex_idx,
    input  logic [WIDTH-1:0]  fwd_ex_data,
    input  logic              fwd_wb_en,
    input  logic [RIDX_W-1:0] fwd_wb_idx,
    input  logic [WIDTH-1:0]  fwd_wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_aluop,
    output logic [WIDTH-1:0]  out_a,
    output logic [WIDTH-1:0]  out_b
);
    typedef struct packed {
        logic [1:0]       aluop;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } issue_t;

    issue_t           in_op, out_op;
    logic [WIDTH-1:0] rs_res, rt_res, imm_ext;

    // Register 0 is hard-wired zero and must never pick up a forward aimed at it.
    function automatic logic [WIDTH-1:0] resolve(input logic [RIDX_W-1:0] idx,
                                                 input logic [WIDTH-1:0]  rf);
        if (idx == '0)                          return '0;
        else if (fwd_ex_en && fwd_ex_idx == idx) return fwd_ex_data;
        else if (fwd_wb_en && fwd_wb_idx == idx) return fwd_wb_data;
        else                                     return rf;
    endfunction

    always_comb begin
        rs_res  = resolve(in_rs_idx, in_rs_val);
        rt_res  = resolve(in_rt_idx, in_rt_val);
        imm_ext = in_sign_ext ? {{(WIDTH-IMM_W){in_imm[IMM_W-1]}}, in_imm}
                              : {{(WIDTH-IMM_W){1'b0}}, in_imm};
        in_op       = '0;
        in_op.aluop = in_aluop;
        in_op.a     = rs_res;
        in_op.b     = in_use_imm ? imm_ext : rt_res;
    end

    issue_skid_buf #(.T(issue_t)) u_skid (
        .clk       (clk),
        .rst       (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_op)
    );

    assign out_aluop = out_op.aluop;
    assign out_a     = out_op.a;
    assign out_b     = out_op.b;
endmodule

// File: tb/tb_alu_operand_issue.sv
// Directed bench for alu_operand_issue: operand forwarding, immediate extension,
// skid-buffer ordering under stall, flush and asynchronous reset.
module tb_alu_operand_issue;
    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready;
    logic [1:0]  in_aluop;
    logic [4:0]  in_rs_idx, in_rt_idx;
    logic [31:0] in_rs_val, in_rt_val;
    logic [15:0] in_imm;
    logic        in_use_imm, in_sign_ext;
    logic        fwd_ex_en, fwd_wb_en;
    logic [4:0]  fwd_ex_idx, fwd_wb_idx;
    logic [31:0] fwd_ex_data, fwd_wb_data;
    logic        out_valid, out_ready;
    logic [1:0]  out_aluop;
    logic [31:0] out_a, out_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_operand_issue dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_aluop(in_aluop),
        .in_rs_idx(in_rs_idx), .in_rt_idx(in_rt_idx),
        .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_sign_ext(in_sign_ext),
        .fwd_ex_en(fwd_ex_en), .fwd_ex_idx(fwd_ex_idx), .fwd_ex_data(fwd_ex_data),
        .fwd_wb_en(fwd_wb_en), .fwd_wb_idx(fwd_wb_idx), .fwd_wb_data(fwd_wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_aluop(out_aluop), .out_a(out_a), .out_b(out_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [1:0] aop, input logic [4:0] rs, input logic [31:0] rsv,
                      input logic [4:0] rt, input logic [31:0] rtv);
        in_valid  = 1'b1;
        in_aluop  = aop;
        in_rs_idx = rs;
        in_rs_val = rsv;
        in_rt_idx = rt;
        in_rt_val = rtv;
    endtask

    task automatic chk_out(input string tag, input logic [1:0] aop,
                           input logic [31:0] a, input logic [31:0] b);
        chk({tag, ".v"}, {31'b0, out_valid}, 32'd1);
        chk({tag, ".op"}, {30'b0, out_aluop}, {30'b0, aop});
        chk({tag, ".a"}, out_a, a);
        chk({tag, ".b"}, out_b, b);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_aluop = 2'b00; in_rs_idx = '0; in_rt_idx = '0; in_rs_val = '0; in_rt_val = '0;
        in_imm = '0; in_use_imm = 1'b0; in_sign_ext = 1'b0;
        fwd_ex_en = 1'b0; fwd_ex_idx = '0; fwd_ex_data = '0;
        fwd_wb_en = 1'b0; fwd_wb_idx = '0; fwd_wb_data = '0;
        step(); step();
        chk("rst.v", {31'b0, out_valid}, 32'd0);
        chk("rst.rdy", {31'b0, in_ready}, 32'd1);
        chk("rst.a", out_a, 32'd0);
        chk("rst.b", out_b, 32'd0);
        chk("rst.op", {30'b0, out_aluop}, 32'd0);
        reset = 1'b0;
        step();

        // Plain register operands
        op(2'b00, 5'd3, 32'd5, 5'd4, 32'd7);
        step();
        chk_out("rf", 2'b00, 32'd5, 32'd7);

        // EX beats WB on the same index
        op(2'b01, 5'd3, 32'd5, 5'd4, 32'd7);
        fwd_ex_en = 1'b1; fwd_ex_idx = 5'd3; fwd_ex_data = 32'h10;
        fwd_wb_en = 1'b1; fwd_wb_idx = 5'd3; fwd_wb_data = 32'h20;
        step();
        chk_out("exwb", 2'b01, 32'h10, 32'd7);

        // WB only, plus rt picks up its own WB forward
        fwd_ex_en = 1'b0;
        op(2'b00, 5'd3, 32'd5, 5'd3, 32'd7);
        step();
        chk_out("wb", 2'b00, 32'h20, 32'h20);

        // Index 0 never forwarded
        op(2'b00, 5'd0, 32'h99, 5'd4, 32'd7);
        fwd_ex_en = 1'b1; fwd_ex_idx = 5'd0; fwd_ex_data = 32'h55;
        fwd_wb_en = 1'b1; fwd_wb_idx = 5'd0; fwd_wb_data = 32'h66;
        step();
        chk_out("zero", 2'b00, 32'd0, 32'd7);

        // Immediate: rt forward must be ignored
        op(2'b01, 5'd3, 32'd5, 5'd4, 32'd7);
        fwd_ex_idx = 5'd4; fwd_wb_en = 1'b0;
        in_use_imm = 1'b1; in_imm = 16'h8000; in_sign_ext = 1'b1;
        step();
        chk_out("sext", 2'b01, 32'd5, 32'hFFFF8000);
        in_sign_ext = 1'b0;
        step();
        chk_out("zext", 2'b01, 32'd5, 32'h00008000);
        in_use_imm = 1'b0; fwd_ex_en = 1'b0;

        // Drain, then stall with two ops
        in_valid = 1'b0;
        step();
        chk("drain.v", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b0;
        op(2'b00, 5'd1, 32'h111, 5'd2, 32'h222);
        step();
        chk("x.rdy", {31'b0, in_ready}, 32'd1);
        op(2'b01, 5'd1, 32'h333, 5'd2, 32'h444);
        step();
        chk("y.rdy", {31'b0, in_ready}, 32'd0);
        chk_out("hold1", 2'b00, 32'h111, 32'h222);
        op(2'b00, 5'd1, 32'h555, 5'd2, 32'h666);  // refused: in_ready=0
        step();
        chk_out("hold2", 2'b00, 32'h111, 32'h222);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk_out("y", 2'b01, 32'h333, 32'h444);
        chk("y.rdy2", {31'b0, in_ready}, 32'd1);
        step();
        chk("nodup", {31'b0, out_valid}, 32'd0);

        // Flush with both entries full and input pending
        out_ready = 1'b0;
        op(2'b00, 5'd1, 32'h1, 5'd2, 32'h2);
        step();
        op(2'b00, 5'd1, 32'h3, 5'd2, 32'h4);
        step();
        flush = 1'b1; out_ready = 1'b1;
        step();
        chk("fl.v", {31'b0, out_valid}, 32'd0);
        chk("fl.rdy", {31'b0, in_ready}, 32'd1);
        flush = 1'b0; in_valid = 1'b0;
        step();
        chk("fl.v2", {31'b0, out_valid}, 32'd0);

        // Flush with main full and an acceptable input: input dropped
        out_ready = 1'b0;
        op(2'b00, 5'd1, 32'h7, 5'd2, 32'h8);
        step();
        op(2'b00, 5'd1, 32'h9, 5'd2, 32'hA);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl2.v", {31'b0, out_valid}, 32'd0);
        step();
        chk("fl2.v2", {31'b0, out_valid}, 32'd0);

        // Async reset with both entries full
        out_ready = 1'b0;
        op(2'b01, 5'd1, 32'hAA, 5'd2, 32'hBB);
        step();
        op(2'b01, 5'd1, 32'hCC, 5'd2, 32'hDD);
        step();
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("ar.v", {31'b0, out_valid}, 32'd0);
        chk("ar.rdy", {31'b0, in_ready}, 32'd1);
        chk("ar.a", out_a, 32'd0);
        chk("ar.b", out_b, 32'd0);
        chk("ar.op", {30'b0, out_aluop}, 32'd0);
        step();
        reset = 1'b0; out_ready = 1'b1;
        step(); step();
        chk("ar.v2", {31'b0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
